// File: rtl/score_counter_display.sv
// Animated BCD score readout: walks a DIGITS-wide counter one unit per step toward a
// clamped binary target and renders the digits as OR-ed 3x5 glyph sprites.

module sprite_gen #(
    parameter int SPRITE_TABLE = 1
) (
    input  logic [3:0] sprite_number_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    input  logic [8:0] h_pos_i,
    input  logic [8:0] v_pos_i,
    output logic       state_o
);
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic [14:0] glyph;
    logic [2:0]  row_bits;

    assign dx = h_pos_i - x_i;
    assign dy = v_pos_i - y_i;

    // Glyph rows are packed top row first, leftmost pixel in the row MSB.
    always_comb begin
        glyph = 15'b0;
        if (SPRITE_TABLE == 0) begin
            glyph = 15'b111_111_111_111_111;
        end else begin
            case (sprite_number_i)
                4'd0: glyph = 15'b111_101_101_101_111;
                4'd1: glyph = 15'b010_110_010_010_111;
                4'd2: glyph = 15'b111_001_111_100_111;
                4'd3: glyph = 15'b111_001_111_001_111;
                4'd4: glyph = 15'b101_101_111_001_001;
                4'd5: glyph = 15'b111_100_111_001_111;
                4'd6: glyph = 15'b111_100_111_101_111;
                4'd7: glyph = 15'b111_001_001_001_001;
                4'd8: glyph = 15'b111_101_111_101_111;
                4'd9: glyph = 15'b111_101_111_001_111;
                default: glyph = 15'b0;
            endcase
        end
    end

    always_comb begin
        case (dy[2:0])
            3'd0:    row_bits = glyph[14:12];
            3'd1:    row_bits = glyph[11:9];
            3'd2:    row_bits = glyph[8:6];
            3'd3:    row_bits = glyph[5:3];
            3'd4:    row_bits = glyph[2:0];
            default: row_bits = 3'b000;
        endcase
        state_o = 1'b0;
        if (dx < 9'd3 && dy < 9'd5) begin
            state_o = row_bits[2'd2 - dx[1:0]];
        end
    end
endmodule

module score_counter_display #(
    parameter int DIGITS        = 6,
    parameter int TARGET_W      = 20,
    parameter int DIGIT_PITCH   = 4,
    parameter int SPRITE_TABLE  = 1,
    parameter int STEP_DIV      = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TARGET_W-1:0] target,
    input  logic [8:0]          X,
    input  logic [8:0]          Y,
    input  logic [8:0]          H_pos,
    input  logic [8:0]          V_pos,
    output logic                pixel,
    output logic                ready,
    output logic                overflow
);
    localparam logic [TARGET_W-1:0] MAXV = TARGET_W'(10 ** DIGITS - 1);
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [DIGITS-1:0][3:0] bcd_q;
    logic [DIGITS-1:0][3:0] bcd_inc_d;
    logic [DIGITS-1:0][3:0] bcd_dec_d;
    logic [TARGET_W-1:0]    shown_q;
    logic [TARGET_W-1:0]    tgt_c;
    logic [PRE_W-1:0]       pre_q;
    logic                   ready_q;
    logic                   overflow_q;
    logic [DIGITS-1:0]      vis;
    logic [DIGITS-1:0]      spr;

    assign tgt_c = (target > MAXV) ? MAXV : target;

    always_comb begin
        logic carry;
        logic borrow;
        carry     = 1'b1;
        borrow    = 1'b1;
        bcd_inc_d = bcd_q;
        bcd_dec_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[i] == 4'd9) begin
                    bcd_inc_d[i] = 4'd0;
                end else begin
                    bcd_inc_d[i] = bcd_q[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd_q[i] == 4'd0) begin
                    bcd_dec_d[i] = 4'd9;
                end else begin
                    bcd_dec_d[i] = bcd_q[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end

    // The binary shadow drives direction and equality; BCD only feeds the glyphs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q      <= '0;
            shown_q    <= '0;
            pre_q      <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= (target > MAXV);
            if (shown_q == tgt_c) begin
                pre_q   <= '0;
                ready_q <= 1'b1;
            end else begin
                ready_q <= 1'b0;
                if (pre_q == PRE_LAST) begin
                    pre_q <= '0;
                    if (shown_q < tgt_c) begin
                        shown_q <= shown_q + 1'b1;
                        bcd_q   <= bcd_inc_d;
                    end else begin
                        shown_q <= shown_q - 1'b1;
                        bcd_q   <= bcd_dec_d;
                    end
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic nz;
        nz  = 1'b0;
        vis = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz     = nz | (bcd_q[i] != 4'd0);
            vis[i] = (i == 0) || (BLANK_LEADING == 0) || nz;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [8:0] OFFS = 9'(((DIGITS - 1 - g) * DIGIT_PITCH) % 512);
        sprite_gen #(
            .SPRITE_TABLE(SPRITE_TABLE)
        ) u_sprite (
            .sprite_number_i(bcd_q[g]),
            .x_i            (X + OFFS),
            .y_i            (Y),
            .h_pos_i        (H_pos),
            .v_pos_i        (V_pos),
            .state_o        (spr[g])
        );
    end

    assign pixel    = |(spr & vis);
    assign ready    = ready_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_score_counter_display.sv
// Randomised bench for score_counter_display: three instances (default, slow step,
// two digits) checked every cycle against a decimal-arithmetic model with a glyph bitmap.
`timescale 1ns/1ps

module tb_score_counter_display;
    localparam int DIG [3] = '{6, 6, 2};
    localparam int DIV [3] = '{1, 4, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] tgt [3];
    logic [8:0]  xp, yp, hp, vp;
    logic        px  [3];
    logic        rdy [3];
    logic        ovf [3];

    int checks = 0;
    int errors = 0;

    int m_shown [3];
    int m_pre   [3];
    bit m_rdy   [3];
    bit m_ovf   [3];

    string FONT [10][5] = '{
        '{"###", "#.#", "#.#", "#.#", "###"},
        '{".#.", "##.", ".#.", ".#.", "###"},
        '{"###", "..#", "###", "#..", "###"},
        '{"###", "..#", "###", "..#", "###"},
        '{"#.#", "#.#", "###", "..#", "..#"},
        '{"###", "#..", "###", "..#", "###"},
        '{"###", "#..", "###", "#.#", "###"},
        '{"###", "..#", "..#", "..#", "..#"},
        '{"###", "#.#", "###", "#.#", "###"},
        '{"###", "#.#", "###", "..#", "###"}
    };

    always #10 clk = ~clk;

    score_counter_display u_d6 (
        .clk(clk), .rst_n(rst_n), .target(tgt[0]), .X(xp), .Y(yp),
        .H_pos(hp), .V_pos(vp), .pixel(px[0]), .ready(rdy[0]), .overflow(ovf[0])
    );

    score_counter_display #(.STEP_DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .target(tgt[1]), .X(xp), .Y(yp),
        .H_pos(hp), .V_pos(vp), .pixel(px[1]), .ready(rdy[1]), .overflow(ovf[1])
    );

    score_counter_display #(.DIGITS(2), .TARGET_W(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .target(tgt[2][7:0]), .X(xp), .Y(yp),
        .H_pos(hp), .V_pos(vp), .pixel(px[2]), .ready(rdy[2]), .overflow(ovf[2])
    );

    function automatic int maxv(int k);
        int p = 1;
        repeat (DIG[k]) p *= 10;
        return p - 1;
    endfunction

    function automatic int clampt(int k);
        return (int'(tgt[k]) > maxv(k)) ? maxv(k) : int'(tgt[k]);
    endfunction

    // Reference: the displayed decimal value moves one unit toward the clamped target
    // every DIV edges of continuous mismatch.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_shown[k] <= 0;
                m_pre[k]   <= 0;
                m_rdy[k]   <= 1'b0;
                m_ovf[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_ovf[k] <= int'(tgt[k]) > maxv(k);
                if (m_shown[k] == clampt(k)) begin
                    m_pre[k] <= 0;
                    m_rdy[k] <= 1'b1;
                end else begin
                    m_rdy[k] <= 1'b0;
                    if (m_pre[k] == DIV[k] - 1) begin
                        m_pre[k]   <= 0;
                        m_shown[k] <= m_shown[k] + ((m_shown[k] < clampt(k)) ? 1 : -1);
                    end else begin
                        m_pre[k] <= m_pre[k] + 1;
                    end
                end
            end
        end
    end

    function automatic logic exp_px(int k, int h, int v);
        int   p10 = 1;
        int   d, x0, dx, dy;
        logic r = 1'b0;
        for (int i = 0; i < DIG[k]; i++) begin
            d  = (m_shown[k] / p10) % 10;
            x0 = (int'(xp) + (DIG[k] - 1 - i) * 4) % 512;
            dx = (h - x0 + 512) % 512;
            dy = (v - int'(yp) + 512) % 512;
            if ((i == 0 || m_shown[k] >= p10) && dx < 3 && dy < 5 && FONT[d][dy][dx] == "#")
                r = 1'b1;
            p10 *= 10;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(string name, int k, int h, int v, logic e);
        hp = 9'(h);
        vp = 9'(v);
        #0.01;
        chk(name, 32'(px[k]), 32'(e));
    endtask

    task automatic nxt();
        @(negedge clk);
        #4;
    endtask

    // Every negedge: flags, then a full bitmap sweep around the digit row.
    initial begin
        int errs [3];
        #5;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_rdy[k]));
                chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
                errs[k] = 0;
            end
            for (int dy = -1; dy <= 5; dy++) begin
                for (int dx = -2; dx <= 27; dx++) begin
                    hp = 9'((int'(xp) + dx + 512) % 512);
                    vp = 9'((int'(yp) + dy + 512) % 512);
                    #0.01;
                    for (int k = 0; k < 3; k++)
                        if (px[k] !== exp_px(k, int'(hp), int'(vp))) errs[k]++;
                end
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("frame%0d_bad_pixels", k), 32'(errs[k]), 32'd0);
        end
    end

    initial begin
        int ones;
        int nt;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tgt[k] = '0;
        xp = 9'd100; yp = 9'd50; hp = '0; vp = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #4 rst_n = 1'b1;

        nxt();
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_overflow", 32'(ovf[0]), 32'd0);
        lit("rst_zero_top", 0, 120, 50, 1'b1);
        lit("rst_zero_hole", 0, 121, 51, 1'b0);
        lit("rst_blank", 0, 118, 50, 1'b0);

        tgt[0] = 20'd12;
        tgt[2] = 20'd150;
        repeat (12) nxt();
        chk("up12_ready_early", 32'(rdy[0]), 32'd0);
        chk("model_at_12", 32'(m_shown[0]), 32'd12);
        lit("up12_one", 0, 116, 51, 1'b1);
        lit("up12_two_r", 0, 122, 51, 1'b1);
        lit("up12_two_l", 0, 120, 51, 1'b0);
        nxt();
        chk("up12_ready", 32'(rdy[0]), 32'd1);

        tgt[0] = 20'd100;
        repeat (89) nxt();
        chk("up100_ready", 32'(rdy[0]), 32'd1);
        chk("d2_sat_ready", 32'(rdy[2]), 32'd1);
        chk("d2_sat_overflow", 32'(ovf[2]), 32'd1);
        chk("model_d2_sat", 32'(m_shown[2]), 32'd99);
        tgt[0] = 20'd95;
        repeat (5) nxt();
        chk("dn95_ready_early", 32'(rdy[0]), 32'd0);
        nxt();
        chk("dn95_ready", 32'(rdy[0]), 32'd1);
        lit("dn95_five_l", 0, 120, 51, 1'b1);
        lit("dn95_five_r", 0, 122, 51, 1'b0);
        lit("dn95_nine_l", 0, 116, 53, 1'b0);
        lit("dn95_nine_r", 0, 118, 53, 1'b1);
        lit("dn95_hundreds_blank", 0, 113, 50, 1'b0);

        tgt[2] = 20'd40;
        nxt();
        chk("d2_ovf_drop", 32'(ovf[2]), 32'd0);
        chk("d2_ready_drop", 32'(rdy[2]), 32'd0);
        repeat (58) nxt();
        chk("d2_dn40_early", 32'(rdy[2]), 32'd0);
        nxt();
        chk("d2_dn40_ready", 32'(rdy[2]), 32'd1);

        tgt[1] = 20'd3;
        repeat (3) nxt();
        lit("div4_edge3_zero", 1, 120, 50, 1'b1);
        nxt();
        lit("div4_edge4_one_l", 1, 120, 50, 1'b0);
        lit("div4_edge4_one_m", 1, 121, 50, 1'b1);
        repeat (8) nxt();
        chk("div4_edge12_ready", 32'(rdy[1]), 32'd0);
        nxt();
        chk("div4_edge13_ready", 32'(rdy[1]), 32'd1);

        tgt[0] = 20'd42;
        repeat (54) nxt();
        chk("v42_ready", 32'(rdy[0]), 32'd1);
        ones = 0;
        for (int v = 50; v <= 54; v++)
            for (int h = 100; h <= 115; h++) begin
                hp = 9'(h); vp = 9'(v);
                #0.01;
                if (px[0] !== 1'b0) ones++;
            end
        chk("v42_leading_blank", 32'(ones), 32'd0);
        lit("v42_four_l", 0, 116, 50, 1'b1);
        lit("v42_four_m", 0, 117, 50, 1'b0);
        lit("v42_two_top", 0, 120, 50, 1'b1);
        lit("v42_two_r1", 0, 121, 51, 1'b0);

        tgt[0] = 20'd999;
        repeat (50) nxt();
        rst_n = 1'b0;
        #0.01;
        chk("midrst_ready", 32'(rdy[0]), 32'd0);
        lit("midrst_zero_top", 0, 120, 50, 1'b1);
        lit("midrst_zero_hole", 0, 121, 51, 1'b0);
        lit("midrst_blank", 0, 118, 50, 1'b0);
        nxt();
        rst_n = 1'b1;

        // Climb past 999 so later random moves cross the thousands carry.
        tgt[0] = 20'd1003;
        repeat (1010) nxt();

        repeat (40) begin
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                nxt();
                rst_n = 1'b1;
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    tgt[0] = 20'($urandom_range(1000000, 1048575));
                end else begin
                    nt = m_shown[0] + int'($urandom_range(0, 120)) - 60;
                    if (nt < 0) nt = 0;
                    tgt[0] = 20'(nt);
                end
                tgt[1] = 20'($urandom_range(0, 30));
                tgt[2] = 20'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) begin
                    xp = ($urandom_range(0, 1) == 0) ? 9'd500 : 9'($urandom_range(0, 511));
                    yp = 9'($urandom_range(0, 511));
                end
            end
            repeat ($urandom_range(5, 80)) nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
